// File: rtl/mix_sequencer_if.sv
// Host command/config and actuator status bundle for the mixing sequencer.
// The master side is the host/driver, the slave side is the sequencer.
interface mix_sequencer_if #(
  parameter int unsigned NUM_INLETS = 3,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned REP_W      = 4
);
  logic                        start;
  logic                        abort;
  logic [NUM_INLETS*CNT_W-1:0] dwell_cfg;
  logic [CNT_W-1:0]            mix_cfg;
  logic [CNT_W-1:0]            flush_cfg;
  logic [REP_W-1:0]            reps_cfg;
  logic [NUM_INLETS-1:0]       inlet_valve;
  logic                        mix_pump;
  logic                        out_valve;
  logic                        busy;
  logic                        done;
  logic                        aborted;
  logic [REP_W-1:0]            cur_rep;

  modport master (
    output start, abort, dwell_cfg, mix_cfg, flush_cfg, reps_cfg,
    input  inlet_valve, mix_pump, out_valve, busy, done, aborted, cur_rep
  );

  modport slave (
    input  start, abort, dwell_cfg, mix_cfg, flush_cfg, reps_cfg,
    output inlet_valve, mix_pump, out_valve, busy, done, aborted, cur_rep
  );
endinterface

// File: rtl/mix_sequencer.sv
// Dispense/mix/flush sequencer for an N-inlet mixing chain: inlets in order, mixer,
// repeated for a programmed number of rounds, then outlet flush and a done pulse.
module mix_sequencer #(
  parameter int unsigned NUM_INLETS = 3,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned REP_W      = 4,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mix_sequencer_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_INLETS > 1) ? $clog2(NUM_INLETS) : 1;
  localparam int unsigned SEL_W = IDX_W + 1;
  localparam int unsigned PRE_W = $clog2(PRESCALE) + 1;
  localparam int unsigned RP_W  = REP_W + 1;
  localparam int unsigned DW_W  = NUM_INLETS * CNT_W;
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPENSE,
    S_MIX,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              aborted_q, aborted_d;
  logic              capture;

  logic [DW_W-1:0]   dwell_q;
  logic [CNT_W-1:0]  mix_q, flush_q;
  logic [REP_W-1:0]  reps_q;

  logic [NUM_INLETS-1:0] inlet_q;
  logic                  pump_q, outv_q, busy_q, done_q;

  // Config seen by the resolver: live inputs while idle, shadow copies while running
  logic [DW_W-1:0]   dw_src;
  logic [CNT_W-1:0]  mix_src, flush_src;
  logic [REP_W-1:0]  reps_eff;

  logic              tick, last_tick;
  logic              go_inlet, go_mix, go_end, go_flush;
  logic [SEL_W-1:0]  seek_from;
  logic              hit_found, first_found;
  logic [IDX_W-1:0]  hit_idx, first_idx;
  logic [CNT_W-1:0]  hit_dw, first_dw;

  always_comb begin
    dw_src    = (state_q == S_IDLE) ? bus.dwell_cfg : dwell_q;
    mix_src   = (state_q == S_IDLE) ? bus.mix_cfg   : mix_q;
    flush_src = (state_q == S_IDLE) ? bus.flush_cfg : flush_q;
    reps_eff  = (state_q == S_IDLE) ? bus.reps_cfg  : reps_q;
    if (reps_eff == '0) reps_eff = REP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pre_q     <= '0;
      rep_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      rep_q     <= rep_d;
      aborted_q <= aborted_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
      mix_q   <= '0;
      flush_q <= '0;
      reps_q  <= '0;
    end else if (capture) begin
      dwell_q <= bus.dwell_cfg;
      mix_q   <= bus.mix_cfg;
      flush_q <= bus.flush_cfg;
      reps_q  <= bus.reps_cfg;
    end
  end

  // Next state; zero-length phases are resolved through in the same cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    rep_d       = rep_q;
    aborted_d   = aborted_q;
    capture     = 1'b0;
    go_inlet    = 1'b0;
    go_mix      = 1'b0;
    go_end      = 1'b0;
    go_flush    = 1'b0;
    seek_from   = '0;
    hit_found   = 1'b0;
    hit_idx     = '0;
    hit_dw      = '0;
    first_found = 1'b0;
    first_idx   = '0;
    first_dw    = '0;

    tick      = (pre_q == '0);
    last_tick = tick && (cnt_q == CNT_W'(1));

    if (state_q == S_DISPENSE || state_q == S_MIX || state_q == S_FLUSH) begin
      if (tick) begin
        pre_d = PRE_RELOAD;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pre_d = pre_q - PRE_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          capture   = 1'b1;
          aborted_d = 1'b0;
          rep_d     = '0;
          go_inlet  = 1'b1;
        end
      end
      S_DISPENSE: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          go_flush  = 1'b1;
        end else if (last_tick) begin
          go_inlet  = 1'b1;
          seek_from = SEL_W'(idx_q) + SEL_W'(1);
        end
      end
      S_MIX: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          go_flush  = 1'b1;
        end else if (last_tick) begin
          go_end = 1'b1;
        end
      end
      S_FLUSH: if (last_tick) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < int'(NUM_INLETS); i++) begin
      if (dw_src[i*CNT_W +: CNT_W] != '0) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = IDX_W'(i);
          first_dw    = dw_src[i*CNT_W +: CNT_W];
        end
        if (!hit_found && SEL_W'(i) >= seek_from) begin
          hit_found = 1'b1;
          hit_idx   = IDX_W'(i);
          hit_dw    = dw_src[i*CNT_W +: CNT_W];
        end
      end
    end

    if (go_inlet) begin
      if (hit_found) begin
        state_d = S_DISPENSE;
        idx_d   = hit_idx;
        cnt_d   = hit_dw;
        pre_d   = PRE_RELOAD;
      end else begin
        go_mix = 1'b1;
      end
    end

    if (go_mix) begin
      if (mix_src != '0) begin
        state_d = S_MIX;
        cnt_d   = mix_src;
        pre_d   = PRE_RELOAD;
      end else begin
        go_end = 1'b1;
      end
    end

    // An empty round makes every remaining round empty, so they collapse together
    if (go_end) begin
      if (!first_found && mix_src == '0) begin
        rep_d    = reps_eff - REP_W'(1);
        go_flush = 1'b1;
      end else if (RP_W'(rep_d) + RP_W'(1) < RP_W'(reps_eff)) begin
        rep_d = rep_d + REP_W'(1);
        pre_d = PRE_RELOAD;
        if (first_found) begin
          state_d = S_DISPENSE;
          idx_d   = first_idx;
          cnt_d   = first_dw;
        end else begin
          state_d = S_MIX;
          cnt_d   = mix_src;
        end
      end else begin
        go_flush = 1'b1;
      end
    end

    if (go_flush) begin
      if (flush_src != '0) begin
        state_d = S_FLUSH;
        cnt_d   = flush_src;
        pre_d   = PRE_RELOAD;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  // Actuator outputs decoded from the next state so they align with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inlet_q <= '0;
      pump_q  <= 1'b0;
      outv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      inlet_q <= (state_d == S_DISPENSE) ? (NUM_INLETS'(1) << idx_d) : '0;
      pump_q  <= (state_d == S_MIX);
      outv_q  <= (state_d == S_FLUSH);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.inlet_valve = inlet_q;
  assign bus.mix_pump    = pump_q;
  assign bus.out_valve   = outv_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.cur_rep     = rep_q;
endmodule

// File: tb/tb_mix_sequencer.sv
// Randomised and directed bench for mix_sequencer: two instances (PRESCALE 1 and 4)
// compared cycle by cycle against a phase-list model built from the configured durations.
module tb_mix_sequencer;
  localparam int unsigned N  = 3;
  localparam int unsigned CW = 16;
  localparam int unsigned RW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_sequencer_if #(.NUM_INLETS(N), .CNT_W(CW), .REP_W(RW)) bus1 ();
  mix_sequencer_if #(.NUM_INLETS(N), .CNT_W(CW), .REP_W(RW)) bus4 ();

  mix_sequencer #(.NUM_INLETS(N), .CNT_W(CW), .REP_W(RW), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  mix_sequencer #(.NUM_INLETS(N), .CNT_W(CW), .REP_W(RW), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct packed {
    logic [N-1:0]  inl;
    logic          pump;
    logic          outv;
    logic          busy;
    logic          done;
    logic          ab;
    logic [RW-1:0] rep;
  } obs_t;

  obs_t exp_q[$];
  obs_t got_q[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) begin
      o.inl = bus4.inlet_valve; o.pump = bus4.mix_pump; o.outv = bus4.out_valve;
      o.busy = bus4.busy; o.done = bus4.done; o.ab = bus4.aborted; o.rep = bus4.cur_rep;
    end else begin
      o.inl = bus1.inlet_valve; o.pump = bus1.mix_pump; o.outv = bus1.out_valve;
      o.busy = bus1.busy; o.done = bus1.done; o.ab = bus1.aborted; o.rep = bus1.cur_rep;
    end
    return o;
  endfunction

  function automatic logic [N*CW-1:0] mk_dw(input int a, input int b, input int c);
    return {CW'(c), CW'(b), CW'(a)};
  endfunction

  task automatic drive(input bit sel, input logic [N*CW-1:0] dw, input logic [CW-1:0] mx,
                       input logic [CW-1:0] fl, input logic [RW-1:0] rp);
    if (sel) begin
      bus4.dwell_cfg = dw; bus4.mix_cfg = mx; bus4.flush_cfg = fl; bus4.reps_cfg = rp;
    end else begin
      bus1.dwell_cfg = dw; bus1.mix_cfg = mx; bus1.flush_cfg = fl; bus1.reps_cfg = rp;
    end
  endtask

  task automatic set_cmd(input bit sel, input bit st, input bit ab);
    if (sel) begin bus4.start = st; bus4.abort = ab; end
    else     begin bus1.start = st; bus1.abort = ab; end
  endtask

  // Expected per-cycle outputs from the cycle after start through the first idle cycle
  function automatic void build_exp(input logic [N*CW-1:0] dw, input logic [CW-1:0] mx,
                                    input logic [CW-1:0] fl, input logic [RW-1:0] rp,
                                    input int p, input int abort_at);
    obs_t o;
    int   eff, last_rep;
    bit   ab;
    exp_q.delete();
    eff = (rp == 0) ? 1 : int'(rp);
    for (int r = 0; r < eff; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        repeat (int'(dw[i*CW +: CW]) * p) begin
          o = '0; o.inl = N'(1) << i; o.busy = 1'b1; o.rep = RW'(r); exp_q.push_back(o);
        end
      end
      repeat (int'(mx) * p) begin
        o = '0; o.pump = 1'b1; o.busy = 1'b1; o.rep = RW'(r); exp_q.push_back(o);
      end
    end
    ab = 1'b0;
    last_rep = eff - 1;
    if (abort_at >= 0 && abort_at < exp_q.size()) begin
      o = exp_q[abort_at];
      if (o.inl != '0 || o.pump) begin
        ab = 1'b1;
        last_rep = int'(o.rep);
        while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      end
    end
    repeat (int'(fl) * p) begin
      o = '0; o.outv = 1'b1; o.busy = 1'b1; o.ab = ab; o.rep = RW'(last_rep); exp_q.push_back(o);
    end
    o = '0; o.busy = 1'b1; o.done = 1'b1; o.ab = ab; o.rep = RW'(last_rep); exp_q.push_back(o);
    o = '0; o.ab = ab; o.rep = RW'(last_rep); exp_q.push_back(o);
  endfunction

  // Pulse start, then record exp_q.size() cycles, optionally injecting abort or a mid-run start/cfg change
  task automatic collect(input bit sel, input int abort_at, input int tamper_at);
    int n;
    n = exp_q.size();
    got_q.delete();
    set_cmd(sel, 1'b1, 1'b0);
    @(negedge clk);
    set_cmd(sel, 1'b0, 1'b0);
    for (int c = 0; c < n; c++) begin
      got_q.push_back(sample(sel));
      set_cmd(sel, c == tamper_at, c == abort_at);
      if (c == tamper_at)
        drive(sel, {CW'($urandom), CW'($urandom), CW'($urandom)}, CW'($urandom), CW'($urandom), RW'($urandom));
      @(negedge clk);
    end
    set_cmd(sel, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, '0, '0); drive(1'b1, '0, '0, '0, '0);
    set_cmd(1'b0, 1'b0, 1'b0); set_cmd(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      tests++;
      if (sample(s != 0) !== obs_t'('0)) begin
        failed++; $display("FAIL reset_state dut%0d got=%h exp=0", s, sample(s != 0));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      tests++;
      if (sample(s != 0) !== obs_t'('0)) begin
        failed++; $display("FAIL reset_idle dut%0d got=%h exp=0", s, sample(s != 0));
      end
    end
  endtask

  task automatic test_basic();
    drive(1'b0, mk_dw(3, 2, 4), 16'd5, 16'd2, 4'd1);
    build_exp(mk_dw(3, 2, 4), 16'd5, 16'd2, 4'd1, 1, -1);
    collect(1'b0, -1, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests++;
      if (got_q[c] !== exp_q[c]) begin
        failed++; $display("FAIL basic cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_skip_reps();
    drive(1'b0, mk_dw(0, 2, 0), 16'd0, 16'd1, 4'd3);
    build_exp(mk_dw(0, 2, 0), 16'd0, 16'd1, 4'd3, 1, -1);
    collect(1'b0, -1, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests++;
      if (got_q[c] !== exp_q[c]) begin
        failed++; $display("FAIL skip_reps cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_abort();
    drive(1'b0, mk_dw(3, 2, 4), 16'd5, 16'd3, 4'd1);
    build_exp(mk_dw(3, 2, 4), 16'd5, 16'd3, 4'd1, 1, 10);
    collect(1'b0, 10, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests++;
      if (got_q[c] !== exp_q[c]) begin
        failed++; $display("FAIL abort cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
    drive(1'b0, mk_dw(1, 0, 1), 16'd2, 16'd1, 4'd1);
    build_exp(mk_dw(1, 0, 1), 16'd2, 16'd1, 4'd1, 1, -1);
    collect(1'b0, -1, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests++;
      if (got_q[c] !== exp_q[c]) begin
        failed++; $display("FAIL abort_clear cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_prescale();
    drive(1'b1, mk_dw(1, 0, 0), 16'd1, 16'd1, 4'd1);
    build_exp(mk_dw(1, 0, 0), 16'd1, 16'd1, 4'd1, 4, -1);
    collect(1'b1, -1, 5);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests++;
      if (got_q[c] !== exp_q[c]) begin
        failed++; $display("FAIL prescale cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    obs_t o;
    drive(1'b0, mk_dw(3, 2, 4), 16'd5, 16'd2, 4'd2);
    set_cmd(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    set_cmd(1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    o = '0; o.inl = 3'b100; o.busy = 1'b1; o.rep = 4'd1;
    tests++;
    if (sample(1'b0) !== o) begin
      failed++; $display("FAIL pre_reset got=%h exp=%h", sample(1'b0), o);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (sample(1'b0) !== obs_t'('0)) begin
      failed++; $display("FAIL async_reset got=%h exp=0", sample(1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, mk_dw(1, 2, 1), 16'd1, 16'd1, 4'd2);
    build_exp(mk_dw(1, 2, 1), 16'd1, 16'd1, 4'd2, 1, -1);
    collect(1'b0, -1, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      tests++;
      if (got_q[c] !== exp_q[c]) begin
        failed++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_all_zero();
    for (int s = 0; s < 2; s++) begin
      drive(s != 0, '0, '0, '0, '0);
      build_exp('0, '0, '0, '0, (s != 0) ? 4 : 1, -1);
      collect(s != 0, -1, -1);
      for (int c = 0; c < exp_q.size(); c++) begin
        tests++;
        if (got_q[c] !== exp_q[c]) begin
          failed++; $display("FAIL all_zero dut%0d cyc=%0d got=%h exp=%h", s, c, got_q[c], exp_q[c]);
        end
      end
    end
  endtask

  task automatic test_ignored();
    drive(1'b0, mk_dw(2, 2, 2), 16'd2, 16'd2, 4'd1);
    set_cmd(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    set_cmd(1'b0, 1'b0, 1'b1);
    tests++;
    if (sample(1'b0).busy !== 1'b0) begin
      failed++; $display("FAIL start_abort_idle busy=%b exp=0", sample(1'b0).busy);
    end
    @(negedge clk);
    set_cmd(1'b0, 1'b0, 1'b0);
    tests++;
    if (sample(1'b0).busy !== 1'b0) begin
      failed++; $display("FAIL abort_idle busy=%b exp=0", sample(1'b0).busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, mk_dw(1, 1, 0), 16'd1, 16'd0, 4'd2);
      build_exp(mk_dw(1, 1, 0), 16'd1, 16'd0, 4'd2, 1, -1);
      collect(1'b0, -1, exp_q.size() - 2);
      for (int c = 0; c < exp_q.size(); c++) begin
        tests++;
        if (got_q[c] !== exp_q[c]) begin
          failed++; $display("FAIL back_to_back run%0d cyc=%0d got=%h exp=%h", k, c, got_q[c], exp_q[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [N*CW-1:0] dw;
    logic [CW-1:0]   mx, fl;
    logic [RW-1:0]   rp;
    bit              sel;
    int              ab_at;
    for (int k = 0; k < 12; k++) begin
      sel   = $urandom_range(0, 1) != 0;
      dw    = mk_dw(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      mx    = CW'($urandom_range(1, 4));
      fl    = CW'($urandom_range(0, 3));
      rp    = RW'($urandom_range(0, 3));
      ab_at = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 40)) : -1;
      drive(sel, dw, mx, fl, rp);
      build_exp(dw, mx, fl, rp, sel ? 4 : 1, ab_at);
      collect(sel, ab_at, -1);
      for (int c = 0; c < exp_q.size(); c++) begin
        tests++;
        if (got_q[c] !== exp_q[c]) begin
          failed++; $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", k, c, got_q[c], exp_q[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip_reps();
    test_abort();
    test_prescale();
    test_reset_midrun();
    test_all_zero();
    test_ignored();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
